life_step_engine: RTL and testbench
===================================

Name: life_step_engine

Overview:
- Computes one Game of Life generation over a row-per-word grid. Reads the current generation from a source bram and writes the next generation to a separate destination bram.
- Sits between the two ping-pong grid memories. It drives the source bram's read port and the destination bram's write port directly.
- The controller swaps the two memory roles between generations.
- The grid is toroidal: rows and columns both wrap.

Parameters:
- GRID_WIDTH, 8: cells per row, equal to the bram word width. Minimum 3.
- GRID_HEIGHT, 200: rows, equal to the bram depth. Minimum 3.
- ADDR_WIDTH, 8: row address width. 2**ADDR_WIDTH >= GRID_HEIGHT.
- POP_WIDTH, 16: population counter width. 2**POP_WIDTH > GRID_WIDTH*GRID_HEIGHT.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to compute a generation; sampled in IDLE only.
- busy  out  1  high while a generation is in progress.
- done  out  1  one-cycle pulse when the last row has been written.
- generation  out  16  count of completed generations; wraps at 2**16.
- population  out  POP_WIDTH  live-cell count of the last completed generation.
- rd_addr  out  ADDR_WIDTH  source bram read address.
- rd_en  out  1  source bram read enable.
- rd_data  in  GRID_WIDTH  source row data, valid the cycle after rd_en.
- wr_addr  out  ADDR_WIDTH  destination bram write address.
- wr_en  out  1  destination bram write enable.
- wr_data  out  GRID_WIDTH  next-generation row.

Behaviour:
- Reset:
  - state=IDLE.
  - busy, done, rd_en, wr_en = 0.
  - rd_addr, wr_addr, wr_data = 0.
  - generation = 0, population = 0.
  - Window registers cleared.
  - Reset mid-run aborts with no further writes. Partially written destination rows are left as-is.
- State machine: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- Start:
  - start sampled high in IDLE at cycle s. Call c = s+1.
  - From c, busy=1 until DONE.
  - start while busy or in DONE is ignored.
- READ:
  - Issues GRID_HEIGHT+2 reads, k=0..GRID_HEIGHT+1, one per cycle at cycle c+k.
  - rd_en=1; rd_addr=(k-1) mod GRID_HEIGHT. Sequence is H-1, 0, 1, ..., H-1, 0.
  - rd_en is 0 in every other state.
- Window:
  - Three row registers top/mid/bot.
  - In cycle c+k+1, rd_data is shifted in: top<=mid, mid<=bot, bot<=rd_data.
- Write:
  - For k>=2, cycle c+k+2 has wr_en=1, wr_addr=k-2 = output row r, wr_data=next(top,mid,bot).
  - Writes for rows 0..H-1 fall at cycles s+5 .. s+H+4, one per cycle, in ascending order.
- DRAIN: covers the two cycles after the last read, until the last write.
- DONE (cycle s+H+5):
  - done=1, busy=0.
  - generation increments.
  - population loads the accumulated count.
  - Returns to IDLE next cycle.
- Cell rule, per column j of mid:
  - Neighbours are top, mid, bot at columns j-1, j+1 mod GRID_WIDTH, plus top and bot at column j. Eight in total.
  - Count is 4 bits.
  - next[j] = (count==3) | (mid[j] & count==2).
- Population:
  - Accumulator cleared at start acceptance.
  - Adds popcount(wr_data) on every write.
  - The visible population output changes only at DONE.
- Source and destination brams are distinct. The block never reads an address it has written in the same generation.

Test Plan (GRID_WIDTH=8, GRID_HEIGHT=8):
- Blinker:
  - Stimulus: row3=8'b00011100, all other rows 0; start.
  - Response: rows 2,3,4 written 8'b00001000, others 0. population=3, generation=1.
  - Second run on the swapped memories restores row3=8'b00011100.
- Timing:
  - Stimulus: start at cycle s.
  - Response: rd_en high s+1..s+10 with addresses 7,0,1,...,7,0. wr_en high s+5..s+12 with addresses 0..7. done pulse at s+13 only. busy high s+1..s+12.
- Toroidal wrap:
  - Stimulus: row0=row7=8'b10000001, a 2x2 block across both seams.
  - Response: output identical, population=4.
- Empty and overpopulated:
  - All-zero grid -> all zero writes, population=0.
  - All-ones grid (every cell has 8 neighbours) -> all zero, population=0.
- Start while busy:
  - Stimulus: start pulses at s and s+3.
  - Response: exactly one done, 8 writes, generation=1. Next start accepted only after return to IDLE.
- Reset mid-run:
  - Stimulus: reset asserted at s+7.
  - Response: next cycle wr_en=rd_en=busy=0, generation=0. No done pulse. A fresh start then completes normally.

Source files
------------

// File: rtl/life_step_engine.sv
// One Game of Life generation over a toroidal row-per-word grid: streams source rows through a
// three-row window, writes next-generation rows to the destination bram, and counts live cells.
module life_step_engine #(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 200,
  parameter int ADDR_WIDTH  = 8,
  parameter int POP_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           generation,
  output logic [POP_WIDTH-1:0]  population,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [GRID_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic [GRID_WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   RD_TOTAL = (ADDR_WIDTH+1)'(GRID_HEIGHT + 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(GRID_HEIGHT - 1);

  state_t                state, state_nxt;
  logic                  accept, rd_issue, finish;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic                  drain_q;
  logic                  in_vld;
  logic [ADDR_WIDTH:0]   in_cnt;
  logic [GRID_WIDTH-1:0] top, mid, bot;
  logic [POP_WIDTH-1:0]  acc;

  function automatic logic [GRID_WIDTH-1:0] next_row(input logic [GRID_WIDTH-1:0] t,
                                                     input logic [GRID_WIDTH-1:0] m,
                                                     input logic [GRID_WIDTH-1:0] b);
    logic [3:0] cnt;
    int         l;
    int         r;
    next_row = '0;
    for (int j = 0; j < GRID_WIDTH; j++) begin
      l   = (j == 0) ? GRID_WIDTH - 1 : j - 1;
      r   = (j == GRID_WIDTH - 1) ? 0 : j + 1;
      cnt = {3'b0, t[l]} + {3'b0, t[j]} + {3'b0, t[r]} +
            {3'b0, m[l]} + {3'b0, m[r]} +
            {3'b0, b[l]} + {3'b0, b[j]} + {3'b0, b[r]};
      next_row[j] = (cnt == 4'd3) | (m[j] & (cnt == 4'd2));
    end
  endfunction

  function automatic logic [POP_WIDTH-1:0] popcount(input logic [GRID_WIDTH-1:0] v);
    popcount = '0;
    for (int j = 0; j < GRID_WIDTH; j++) begin
      popcount = popcount + POP_WIDTH'(v[j]);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_issue  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = READ;
          accept    = 1'b1;
          rd_issue  = 1'b1;
        end
      end
      READ: begin
        if (rd_cnt == RD_TOTAL) state_nxt = DRAIN;
        else                    rd_issue  = 1'b1;
      end
      DRAIN: begin
        if (drain_q) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read side: first read is the wrapped row H-1, then 0..H-1, then row 0 again.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      rd_cnt     <= '0;
      drain_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      generation <= '0;
      population <= '0;
    end else begin
      rd_en   <= rd_issue;
      drain_q <= (state == DRAIN) && !drain_q;
      done    <= finish;
      if (accept) begin
        rd_addr <= LAST_ROW;
        rd_cnt  <= (ADDR_WIDTH+1)'(1);
        busy    <= 1'b1;
      end else if (rd_issue) begin
        rd_addr <= (rd_addr == LAST_ROW) ? '0 : rd_addr + 1'b1;
        rd_cnt  <= rd_cnt + 1'b1;
      end
      if (finish) begin
        busy       <= 1'b0;
        generation <= generation + 16'd1;
        population <= acc + (wr_en ? popcount(wr_data) : '0);
      end
    end
  end

  // Window and write side; a row is complete once two earlier rows sit in mid/bot.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_vld  <= 1'b0;
      in_cnt  <= '0;
      top     <= '0;
      mid     <= '0;
      bot     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      acc     <= '0;
    end else begin
      in_vld <= rd_en;
      wr_en  <= 1'b0;
      if (wr_en) acc <= acc + popcount(wr_data);
      if (in_vld) begin
        top    <= mid;
        mid    <= bot;
        bot    <= rd_data;
        in_cnt <= in_cnt + 1'b1;
        if (in_cnt >= (ADDR_WIDTH+1)'(2)) begin
          wr_en   <= 1'b1;
          wr_addr <= ADDR_WIDTH'(in_cnt - (ADDR_WIDTH+1)'(2));
          wr_data <= next_row(mid, bot, rd_data);
        end
      end
      if (accept) begin
        in_cnt <= '0;
        acc    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine on an 8x8 torus with two modelled brams and a cell-level reference.
module tb_life_step_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 3;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [15:0]   generation;
  logic [PW-1:0] population;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [W-1:0]  rd_data = '0;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [W-1:0]  wr_data;

  always #5 clk = ~clk;

  life_step_engine #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .ADDR_WIDTH(AW), .POP_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .generation(generation), .population(population),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data)
  );

  // Two ping-pong brams: sel picks the source, the other is the destination.
  logic [7:0] mem [0:1][0:7];
  logic       sel = 1'b0;
  logic       ld_en = 1'b0;
  logic       ld_sel = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [7:0] ld_dat = '0;
  int         wr_total = 0;
  int         done_total = 0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[sel][rd_addr];
    if (wr_en) mem[!sel][wr_addr] <= wr_data;
    if (ld_en) mem[ld_sel][ld_addr] <= ld_dat;
    if (wr_en) wr_total <= wr_total + 1;
    if (done)  done_total <= done_total + 1;
  end

  int         checks = 0;
  int         fails = 0;
  int         exp_gen = 0;
  int         exp_pop;
  int         w0, d0;
  logic [7:0] cur [0:7];
  logic [7:0] exp_row [0:7];

  // Reference: count the eight toroidal neighbours of every cell directly.
  task automatic compute_model();
    int n;
    bit alive, nx;
    exp_pop = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(cur[(r + dr + H) % H][(c + dc + W) % W]);
        alive = cur[r][c];
        nx = (n == 3) || (alive && n == 2);
        exp_row[r][c] = nx;
        exp_pop += int'(nx);
      end
    end
  endtask

  task automatic load_grid(input logic s);
    for (int r = 0; r < H; r++) begin
      ld_en = 1'b1; ld_sel = s; ld_addr = 3'(r); ld_dat = cur[r];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic run_gen(output bit ok);
    w0 = wr_total; d0 = done_total;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    exp_gen = (exp_gen + 1) % 65536;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy, done, rd_en, wr_en} !== 4'b0) begin fails++;
      $display("FAIL reset_ctrl: busy/done/rd_en/wr_en=%b expected 0000", {busy, done, rd_en, wr_en}); end
    checks++; if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin fails++;
      $display("FAIL reset_bus: rd_addr=%0d wr_addr=%0d wr_data=%h expected 0", rd_addr, wr_addr, wr_data); end
    checks++; if (generation !== 16'd0 || population !== '0) begin fails++;
      $display("FAIL reset_counts: gen=%0d pop=%0d expected 0", generation, population); end
  endtask

  task automatic test_blinker();
    bit ok;
    logic [7:0] e;
    for (int r = 0; r < H; r++) cur[r] = 8'hA5;
    load_grid(1'b1);
    for (int r = 0; r < H; r++) cur[r] = (r == 3) ? 8'b00011100 : 8'h00;
    load_grid(1'b0);
    sel = 1'b0;
    run_gen(ok);
    checks++; if (!ok) begin fails++; $display("FAIL blinker_done: got timeout expected done"); end
    for (int r = 0; r < H; r++) begin
      e = (r >= 2 && r <= 4) ? 8'b00001000 : 8'h00;
      checks++; if (mem[1][r] !== e) begin fails++;
        $display("FAIL blinker_row%0d: got %b expected %b", r, mem[1][r], e); end
    end
    checks++; if (population !== PW'(3)) begin fails++;
      $display("FAIL blinker_pop: got %0d expected 3", population); end
    checks++; if (generation !== 16'(exp_gen)) begin fails++;
      $display("FAIL blinker_gen: got %0d expected %0d", generation, exp_gen); end
    for (int r = 0; r < H; r++) cur[r] = 8'hA5;
    load_grid(1'b0);
    sel = 1'b1;
    run_gen(ok);
    checks++; if (!ok) begin fails++; $display("FAIL blinker2_done: got timeout expected done"); end
    for (int r = 0; r < H; r++) begin
      e = (r == 3) ? 8'b00011100 : 8'h00;
      checks++; if (mem[0][r] !== e) begin fails++;
        $display("FAIL blinker2_row%0d: got %b expected %b", r, mem[0][r], e); end
    end
    checks++; if (generation !== 16'(exp_gen)) begin fails++;
      $display("FAIL blinker2_gen: got %0d expected %0d", generation, exp_gen); end
    sel = 1'b0;
  endtask

  task automatic test_timing();
    bit         er, ew, ed, eb;
    logic [2:0] ea;
    start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      er = (i <= 10); ew = (i >= 5 && i <= 12); ed = (i == 13); eb = (i <= 12);
      checks++; if (rd_en !== er) begin fails++;
        $display("FAIL timing_rd_en s+%0d: got %b expected %b", i, rd_en, er); end
      if (er) begin
        ea = 3'((i + 6) % 8);
        checks++; if (rd_addr !== ea) begin fails++;
          $display("FAIL timing_rd_addr s+%0d: got %0d expected %0d", i, rd_addr, ea); end
      end
      checks++; if (wr_en !== ew) begin fails++;
        $display("FAIL timing_wr_en s+%0d: got %b expected %b", i, wr_en, ew); end
      if (ew) begin
        ea = 3'(i - 5);
        checks++; if (wr_addr !== ea) begin fails++;
          $display("FAIL timing_wr_addr s+%0d: got %0d expected %0d", i, wr_addr, ea); end
      end
      checks++; if (done !== ed) begin fails++;
        $display("FAIL timing_done s+%0d: got %b expected %b", i, done, ed); end
      checks++; if (busy !== eb) begin fails++;
        $display("FAIL timing_busy s+%0d: got %b expected %b", i, busy, eb); end
    end
    exp_gen = (exp_gen + 1) % 65536;
    checks++; if (generation !== 16'(exp_gen)) begin fails++;
      $display("FAIL timing_gen: got %0d expected %0d", generation, exp_gen); end
  endtask

  task automatic test_patterns();
    bit ok;
    for (int p = 0; p < 8; p++) begin
      for (int r = 0; r < H; r++) begin
        case (p)
          0:       cur[r] = (r == 0 || r == 7) ? 8'b10000001 : 8'h00;
          1:       cur[r] = 8'h00;
          2:       cur[r] = 8'hFF;
          3:       cur[r] = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
          default: cur[r] = 8'($urandom_range(0, 255));
        endcase
      end
      load_grid(1'b0);
      compute_model();
      run_gen(ok);
      checks++; if (!ok) begin fails++; $display("FAIL pat%0d_done: got timeout expected done", p); end
      for (int r = 0; r < H; r++) begin
        checks++; if (mem[1][r] !== exp_row[r]) begin fails++;
          $display("FAIL pat%0d_row%0d: got %b expected %b", p, r, mem[1][r], exp_row[r]); end
      end
      if (p == 0) begin
        checks++; if (mem[1][0] !== 8'b10000001 || mem[1][7] !== 8'b10000001 || population !== PW'(4)) begin
          fails++; $display("FAIL wrap_block: rows0/7=%b/%b pop=%0d expected 10000001 and 4",
                            mem[1][0], mem[1][7], population); end
      end
      checks++; if (population !== PW'(exp_pop)) begin fails++;
        $display("FAIL pat%0d_pop: got %0d expected %0d", p, population, exp_pop); end
      checks++; if (generation !== 16'(exp_gen)) begin fails++;
        $display("FAIL pat%0d_gen: got %0d expected %0d", p, generation, exp_gen); end
      checks++; if (wr_total - w0 !== 8 || done_total - d0 !== 1) begin fails++;
        $display("FAIL pat%0d_counts: writes=%0d dones=%0d expected 8 and 1", p, wr_total - w0, done_total - d0); end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok = 1'b0;
    for (int r = 0; r < H; r++) cur[r] = 8'($urandom_range(0, 255));
    load_grid(1'b0);
    compute_model();
    w0 = wr_total; d0 = done_total;
    start = 1'b1;
    for (int i = 1; i < 40; i++) begin
      @(posedge clk); #1;
      start = (i == 3);
      if (done) begin ok = 1'b1; break; end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (!ok) begin fails++; $display("FAIL busy_start_done: got timeout expected done"); end
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL busy_start_in_done: busy=%b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin fails++;
      $display("FAIL busy_start_idle: busy=%b rd_en=%b expected 0 0", busy, rd_en); end
    exp_gen = (exp_gen + 1) % 65536;
    checks++; if (wr_total - w0 !== 8 || done_total - d0 !== 1) begin fails++;
      $display("FAIL busy_start_counts: writes=%0d dones=%0d expected 8 and 1", wr_total - w0, done_total - d0); end
    checks++; if (generation !== 16'(exp_gen)) begin fails++;
      $display("FAIL busy_start_gen: got %0d expected %0d", generation, exp_gen); end
    for (int r = 0; r < H; r++) begin
      checks++; if (mem[1][r] !== exp_row[r]) begin fails++;
        $display("FAIL busy_start_row%0d: got %b expected %b", r, mem[1][r], exp_row[r]); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int w1;
    for (int r = 0; r < H; r++) cur[r] = 8'($urandom_range(0, 255));
    load_grid(1'b0);
    d0 = done_total;
    start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({wr_en, rd_en, busy, done} !== 4'b0) begin fails++;
      $display("FAIL midreset_ctrl: wr_en/rd_en/busy/done=%b expected 0000", {wr_en, rd_en, busy, done}); end
    checks++; if (generation !== 16'd0) begin fails++;
      $display("FAIL midreset_gen: got %0d expected 0", generation); end
    w1 = wr_total;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (wr_total !== w1 || done_total !== d0) begin fails++;
      $display("FAIL midreset_quiet: writes=%0d dones=%0d expected 0 0", wr_total - w1, done_total - d0); end
    exp_gen = 0;
    compute_model();
    run_gen(ok);
    checks++; if (!ok) begin fails++; $display("FAIL midreset_rerun_done: got timeout expected done"); end
    for (int r = 0; r < H; r++) begin
      checks++; if (mem[1][r] !== exp_row[r]) begin fails++;
        $display("FAIL midreset_row%0d: got %b expected %b", r, mem[1][r], exp_row[r]); end
    end
    checks++; if (generation !== 16'd1 || population !== PW'(exp_pop)) begin fails++;
      $display("FAIL midreset_counts: gen=%0d pop=%0d expected 1 and %0d", generation, population, exp_pop); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_blinker();
    test_timing();
    test_patterns();
    test_start_while_busy();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
